// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end.
package inst_fetch_queue_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic [WORD_WIDTH-1:0] FETCH_RESET_PC = 32'hBFC0_0000;
  localparam int INST_BYTES = 4;

  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch front-end bundle: redirect, IF/ID dequeue, SRAM request/return, occupancy.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              deq_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              inst_sram_en;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_rdata;
  logic [$clog2(DEPTH):0] count;

  modport master (
    input  redirect_valid, redirect_pc, deq_ready, inst_sram_rdata,
    output out_valid, out_instr, out_pc, inst_sram_en, inst_sram_addr, count
  );

  modport slave (
    output redirect_valid, redirect_pc, deq_ready, inst_sram_rdata,
    input  out_valid, out_instr, out_pc, inst_sram_en, inst_sram_addr, count
  );
endinterface

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Register-based FIFO with flush; the head is read straight from registered storage.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] headData,
  output logic             headValid,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic full;

  assign full      = (count == CNT_W'(DEPTH));
  assign headValid = (count != '0);
  assign headData  = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= pushData;
  end

  // The fetch credit scheme must never let a return land on a full queue.
  noPushWhenFull: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC, credit-limited SRAM issue, fixed-latency return pipe and the output FIFO.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int SRAM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input logic clk,
  input logic rst,
  inst_fetch_queue_if.master bus
);
  localparam int CNT_W    = countWidth(DEPTH);
  localparam int CREDIT_W = CNT_W + 2;

  logic [ADDR_W-1:0]   fpc;
  logic [SRAM_LAT-1:0] pipeValid;
  logic [ADDR_W-1:0]   pipePc [SRAM_LAT];
  logic [CNT_W-1:0]    fifoCount;
  logic                fifoValid;
  logic [ADDR_W+DATA_W-1:0] headData;
  logic [CREDIT_W-1:0] inflight, creditUsed;
  logic deqFire, issue, push;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LAT; i++) inflight = inflight + CREDIT_W'(pipeValid[i]);
  end

  // In-flight reads are counted as already occupying a FIFO slot.
  assign deqFire    = fifoValid & bus.deq_ready;
  assign creditUsed = inflight + CREDIT_W'(fifoCount) - CREDIT_W'(deqFire);
  assign issue      = ~rst & ~bus.redirect_valid & (creditUsed < CREDIT_W'(DEPTH));
  assign push       = pipeValid[SRAM_LAT-1] & ~bus.redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     fpc <= RESET_PC;
    else if (bus.redirect_valid) fpc <= bus.redirect_pc;
    else if (issue)              fpc <= fpc + ADDR_W'(INST_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pipePc[i] <= ADDR_W'(ZERO_WORD);
    end else begin
      pipeValid[0] <= issue;
      pipePc[0]    <= fpc;
      for (int i = 1; i < SRAM_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1] & ~bus.redirect_valid;
        pipePc[i]    <= pipePc[i-1];
      end
    end
  end

  sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ({pipePc[SRAM_LAT-1], bus.inst_sram_rdata}),
    .pop      (deqFire),
    .flush    (bus.redirect_valid),
    .headData (headData),
    .headValid(fifoValid),
    .count    (fifoCount)
  );

  assign bus.out_valid      = fifoValid;
  assign bus.out_pc         = headData[ADDR_W+DATA_W-1:DATA_W];
  assign bus.out_instr      = headData[DATA_W-1:0];
  assign bus.count          = fifoCount;
  assign bus.inst_sram_en   = issue;
  assign bus.inst_sram_addr = fpc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench: cycle table on a 1-cycle-latency queue, then reset and 2-cycle-latency sequences.
module tb_inst_fetch_queue;
  localparam logic [31:0] B = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus1 ();
  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus2 ();

  inst_fetch_queue #(.SRAM_LAT(1), .DEPTH(4)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  inst_fetch_queue #(.SRAM_LAT(2), .DEPTH(4)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  // SRAM models return the word equal to its address.
  logic [31:0] sram1, sram2a, sram2b;
  always @(posedge clk) begin
    sram1  <= bus1.inst_sram_addr;
    sram2a <= bus2.inst_sram_addr;
    sram2b <= sram2a;
  end
  assign bus1.inst_sram_rdata = sram1;
  assign bus2.inst_sram_rdata = sram2b;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] redirPc;
    logic        deq;
    logic        expEn;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    int          expCount;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic redir, input logic [31:0] redirPc, input logic deq,
                              input logic expEn, input logic [31:0] expAddr,
                              input logic expValid, input logic [31:0] expPc, input int expCount);
    vec_t v;
    v.redir = redir; v.redirPc = redirPc; v.deq = deq;
    v.expEn = expEn; v.expAddr = expAddr; v.expValid = expValid;
    v.expPc = expPc; v.expCount = expCount;
    return v;
  endfunction

  initial begin
    logic [31:0] expNext;
    int pops;

    bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0; bus1.deq_ready = 1'b1;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0; bus2.deq_ready = 1'b1;

    // Free run, 10-cycle stall, resume, redirect with 3 queued + 1 returning,
    // back-to-back redirects, address wrap.
    vecs.push_back(mk(0, 0, 1, 1, B,        0, 0,      0)); // c0
    vecs.push_back(mk(0, 0, 1, 1, B+4,      0, 0,      0));
    vecs.push_back(mk(0, 0, 1, 1, B+8,      1, B,      1));
    vecs.push_back(mk(0, 0, 1, 1, B+'hC,    1, B+4,    1));
    vecs.push_back(mk(0, 0, 0, 1, B+'h10,   1, B+8,    1)); // c4 stall begins
    vecs.push_back(mk(0, 0, 0, 1, B+'h14,   1, B+8,    2));
    vecs.push_back(mk(0, 0, 0, 0, B+'h18,   1, B+8,    3));
    for (int i = 7; i <= 13; i++) vecs.push_back(mk(0, 0, 0, 0, B+'h18, 1, B+8, 4));
    vecs.push_back(mk(0, 0, 1, 1, B+'h18,   1, B+8,    4)); // c14 resume
    vecs.push_back(mk(0, 0, 1, 1, B+'h1C,   1, B+'hC,  3));
    vecs.push_back(mk(0, 0, 1, 1, B+'h20,   1, B+'h10, 3));
    vecs.push_back(mk(0, 0, 1, 1, B+'h24,   1, B+'h14, 3));
    vecs.push_back(mk(0, 0, 1, 1, B+'h28,   1, B+'h18, 3));
    vecs.push_back(mk(0, 0, 1, 1, B+'h2C,   1, B+'h1C, 3));
    vecs.push_back(mk(1, 32'h8000_0100, 1, 0, B+'h30, 1, B+'h20, 3)); // c20 redirect
    vecs.push_back(mk(0, 0, 1, 1, 32'h8000_0100, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h8000_0104, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h8000_0108, 1, 32'h8000_0100, 1));
    vecs.push_back(mk(0, 0, 1, 1, 32'h8000_010C, 1, 32'h8000_0104, 1));
    vecs.push_back(mk(1, 32'h0000_1000, 1, 0, 32'h8000_0110, 1, 32'h8000_0108, 1)); // c25
    vecs.push_back(mk(1, 32'h0000_2000, 1, 0, 32'h0000_1000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_2000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_2004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_2008, 1, 32'h0000_2000, 1));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_200C, 1, 32'h0000_2004, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFF8, 1, 0, 32'h0000_2010, 1, 32'h0000_2008, 1)); // c31
    vecs.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8, 1));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 1));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_0008, 1, 32'h0000_0000, 1));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      bus1.redirect_valid = vecs[i].redir;
      bus1.redirect_pc    = vecs[i].redirPc;
      bus1.deq_ready      = vecs[i].deq;
      @(negedge clk);
      chk($sformatf("c%0d en", i),    32'(bus1.inst_sram_en), 32'(vecs[i].expEn));
      chk($sformatf("c%0d addr", i),  bus1.inst_sram_addr, vecs[i].expAddr);
      chk($sformatf("c%0d valid", i), 32'(bus1.out_valid), 32'(vecs[i].expValid));
      chk($sformatf("c%0d count", i), 32'(bus1.count), 32'(vecs[i].expCount));
      if (vecs[i].expValid) begin
        chk($sformatf("c%0d pc", i),    bus1.out_pc, vecs[i].expPc);
        chk($sformatf("c%0d instr", i), bus1.out_instr, vecs[i].expPc);
      end
    end

    // Asynchronous reset mid-stream while a redirect is being requested.
    @(posedge clk);
    #1;
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 32'h1234_5678;
    #2 rst = 1'b1;
    #1;
    chk("rst u1 valid", 32'(bus1.out_valid), 0);
    chk("rst u1 count", 32'(bus1.count), 0);
    chk("rst u1 en",    32'(bus1.inst_sram_en), 0);
    chk("rst u1 addr",  bus1.inst_sram_addr, B);
    chk("rst u2 valid", 32'(bus2.out_valid), 0);
    chk("rst u2 count", 32'(bus2.count), 0);
    chk("rst u2 addr",  bus2.inst_sram_addr, B);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.deq_ready = 1'b1;
    bus2.deq_ready = 1'b1;

    // Restart from the reset PC; u2 (2-cycle latency) must stream one per cycle.
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (c <= 3) begin
        chk($sformatf("rs%0d u1 valid", c), 32'(bus1.out_valid), 32'(c >= 2));
        chk($sformatf("rs%0d u1 addr", c),  bus1.inst_sram_addr, B + 32'(4*c));
        if (c >= 2) chk($sformatf("rs%0d u1 pc", c), bus1.out_pc, B + 32'(4*(c-2)));
      end
      chk($sformatf("rs%0d u2 valid", c), 32'(bus2.out_valid), 32'(c >= 3));
      chk($sformatf("rs%0d u2 count", c), 32'(bus2.count), (c >= 3) ? 1 : 0);
      if (c >= 3) begin
        chk($sformatf("rs%0d u2 pc", c),    bus2.out_pc, B + 32'(4*(c-3)));
        chk($sformatf("rs%0d u2 instr", c), bus2.out_instr, B + 32'(4*(c-3)));
      end
    end

    // Random back-pressure on u2; the popped PCs must stay gapless.
    expNext = B + 32'h28;
    pops = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      bus2.deq_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus2.out_valid && bus2.deq_ready) begin
        chk($sformatf("rnd%0d pc", k),    bus2.out_pc, expNext);
        chk($sformatf("rnd%0d instr", k), bus2.out_instr, expNext);
        expNext = expNext + 4;
        pops++;
      end
      chk($sformatf("rnd%0d overfull", k), 32'(bus2.count > 3'd4), 0);
    end
    chk("rnd enough pops", 32'(pops >= 40), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
